hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage RISC-V core with I-cache. It generates the stall and flush controls for the PC register, the IF/ID register, and the ID/EX register, plus the EX operand forwarding selects. It resolves load-use hazards, taken-branch redirects and I-cache miss waits, including a branch redirect that arrives while a refill is in flight. It also keeps a saturating stall-cycle counter and a sticky miss-timeout flag.

---
 rtl/hazard_ctrl.sv | 170 +++++++++++++++++
 tb/tb_hazard_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : hazard_ctrl                                                     |
// | Purpose  : Stall/flush sequencing, EX forwarding selects and miss tracking |
// |            for a 5-stage RISC-V pipeline with an I-cache.                  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module hazard_ctrl #(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             icache_req,
  input  logic             icache_hit,
  input  logic             icache_ready,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic             ResultSrcE0,
  input  logic             PCSrcE,
  input  logic             RegWriteM,
  input  logic [4:0]       RdM,
  input  logic             RegWriteW,
  input  logic [4:0]       RdW,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             miss_timeout
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] c_TIMEOUT    = TMR_W'(TIMEOUT);
  localparam logic [TMR_W-1:0] c_TIMEOUT_M1 = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_MISS   = 2'd1,
    S_CANCEL = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [TMR_W-1:0]  r_miss_timer;
  logic [CNT_W-1:0]  r_stall_cycles;
  logic              r_miss_timeout;

  logic              w_lw_stall;
  logic              w_miss;
  logic              w_timer_hit;
  logic              w_stall_f;
  logic              w_stall_d;
  logic              w_flush_d;
  logic              w_flush_e;
  logic [1:0]        w_fwd_a;
  logic [1:0]        w_fwd_b;

  assign w_lw_stall = ResultSrcE0 && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
  assign w_miss     = icache_req && !icache_hit;

  // Memory stage holds the younger result, so it wins over writeback.
  always_comb begin
    w_fwd_a = 2'b00;
    w_fwd_b = 2'b00;
    if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E))
      w_fwd_a = 2'b10;
    else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E))
      w_fwd_a = 2'b01;
    if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E))
      w_fwd_b = 2'b10;
    else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E))
      w_fwd_b = 2'b01;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_state <= S_RUN;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_stall_f = 1'b0;
    w_stall_d = 1'b0;
    w_flush_d = 1'b0;
    w_flush_e = 1'b0;
    case (r_state)
      S_RUN: begin
        w_stall_f = w_lw_stall;
        w_stall_d = w_lw_stall;
        w_flush_e = w_lw_stall || PCSrcE;
        w_flush_d = PCSrcE;
        if (w_miss) begin
          w_next    = S_MISS;
          w_stall_f = 1'b1;
          if (!w_lw_stall)
            w_flush_d = 1'b1;
        end
      end
      S_MISS: begin
        w_stall_f = 1'b1;
        w_stall_d = w_lw_stall;
        w_flush_d = !w_lw_stall;
        w_flush_e = w_lw_stall;
        // A redirect releases the PC for one cycle; any refill now in flight is wrong-path.
        if (PCSrcE) begin
          w_stall_f = 1'b0;
          w_flush_d = 1'b1;
          w_flush_e = 1'b1;
          w_next    = S_CANCEL;
        end else if (icache_ready) begin
          w_next    = S_RUN;
        end
      end
      S_CANCEL: begin
        w_stall_f = 1'b1;
        w_stall_d = 1'b0;
        w_flush_d = 1'b1;
        w_flush_e = w_lw_stall || PCSrcE;
        if (icache_ready)
          w_next = S_RUN;
      end
      default: begin
        w_next = S_RUN;
      end
    endcase
  end

  assign w_timer_hit = (r_state != S_RUN) && (r_miss_timer >= c_TIMEOUT_M1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_miss_timer   <= '0;
      r_miss_timeout <= 1'b0;
    end else begin
      if (w_next == S_RUN)
        r_miss_timer <= '0;
      else if ((r_state != S_RUN) && (r_miss_timer != c_TIMEOUT))
        r_miss_timer <= r_miss_timer + 1'b1;
      if (w_timer_hit)
        r_miss_timeout <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_stall_cycles <= '0;
    else if (StallF && (r_stall_cycles != {CNT_W{1'b1}}))
      r_stall_cycles <= r_stall_cycles + 1'b1;
  end

  // Reset forces a bubble into both pipeline registers and frees the PC.
  assign StallF       = rst && w_stall_f;
  assign StallD       = rst && w_stall_d;
  assign FlushD       = !rst || w_flush_d;
  assign FlushE       = !rst || w_flush_e;
  assign ForwardAE    = rst ? w_fwd_a : 2'b00;
  assign ForwardBE    = rst ? w_fwd_b : 2'b00;
  assign stall_cycles = r_stall_cycles;
  assign miss_timeout = r_miss_timeout;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_hazard_ctrl                                                  |
// | Purpose  : Directed stimulus with a behavioural reference for hazard_ctrl. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_hazard_ctrl;

  localparam int TMO   = 8;
  localparam int CW    = 4;
  localparam int SATV  = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic icache_req, icache_hit, icache_ready;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic ResultSrcE0, PCSrcE, RegWriteM, RegWriteW;
  logic StallF, StallD, FlushD, FlushE, miss_timeout;
  logic [1:0] ForwardAE, ForwardBE;
  logic [CW-1:0] stall_cycles;

  int checks = 0;
  int errs   = 0;
  logic chk_en = 1'b0;

  // Reference: mode 0 fetching, 1 waiting on a good-path refill, 2 waiting on a stale refill.
  int m_mode   = 0;
  int m_wait   = 0;
  int m_flag   = 0;
  int m_stalls = 0;

  hazard_ctrl #(.TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .icache_req(icache_req), .icache_hit(icache_hit), .icache_ready(icache_ready),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
    .RegWriteM(RegWriteM), .RdM(RdM), .RegWriteW(RegWriteW), .RdW(RdW),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .stall_cycles(stall_cycles), .miss_timeout(miss_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  // Returns {StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE}.
  function automatic logic [7:0] expect_ctrl();
    logic lw, sf, sd, fd, fe;
    lw = ResultSrcE0 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
    sf = 0; sd = 0; fd = 0; fe = 0;
    if (!rst) return 8'b0011_0000;
    if (m_mode == 0) begin
      sf = lw || (icache_req && !icache_hit);
      sd = lw;
      fe = lw || PCSrcE;
      fd = (icache_req && !icache_hit && !lw) ? 1'b1 : PCSrcE;
    end else if (m_mode == 1) begin
      sd = lw;
      if (PCSrcE) begin
        sf = 0; fd = 1; fe = 1;
      end else begin
        sf = 1; fd = !lw; fe = lw;
      end
    end else begin
      sf = 1; sd = 0; fd = 1; fe = lw || PCSrcE;
    end
    return {sf, sd, fd, fe, fwd_sel(Rs1E), fwd_sel(Rs2E)};
  endfunction

  function automatic int next_mode();
    case (m_mode)
      0:       return (icache_req && !icache_hit) ? 1 : 0;
      1:       return PCSrcE ? 2 : (icache_ready ? 0 : 1);
      default: return icache_ready ? 0 : 2;
    endcase
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_mode <= 0; m_wait <= 0; m_flag <= 0; m_stalls <= 0;
    end else begin
      if (m_mode != 0) begin
        if (m_wait + 1 >= TMO) m_flag <= 1;
        m_wait <= (next_mode() == 0) ? 0 : m_wait + 1;
      end
      if (expect_ctrl() >> 7 != 0 && m_stalls < SATV) m_stalls <= m_stalls + 1;
      m_mode <= next_mode();
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [7:0] e;
      e = expect_ctrl();
      check("cmp StallF",    32'(StallF),       32'(e[7]));
      check("cmp StallD",    32'(StallD),       32'(e[6]));
      check("cmp FlushD",    32'(FlushD),       32'(e[5]));
      check("cmp FlushE",    32'(FlushE),       32'(e[4]));
      check("cmp ForwardAE", 32'(ForwardAE),    32'(e[3:2]));
      check("cmp ForwardBE", 32'(ForwardBE),    32'(e[1:0]));
      check("cmp stall_cycles", 32'(stall_cycles), 32'(m_stalls));
      check("cmp miss_timeout", 32'(miss_timeout), 32'(m_flag));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    icache_req = 0; icache_hit = 0; icache_ready = 0;
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    ResultSrcE0 = 0; PCSrcE = 0; RegWriteM = 0; RegWriteW = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 0;
    tick(); tick();
    rst = 1;
  endtask

  initial begin
    idle();
    rst = 0;
    tick(); tick();
    chk_en = 1;
    #2;
    check("reset StallF", 32'(StallF), 0);
    check("reset FlushD", 32'(FlushD), 1);
    check("reset FlushE", 32'(FlushE), 1);
    check("reset stall_cycles", 32'(stall_cycles), 0);
    tick();
    rst = 1;

    // Load-use hazard and the x0 exemption
    ResultSrcE0 = 1; RdE = 5; Rs1D = 5; #2;
    check("lw StallF", 32'(StallF), 1);
    check("lw StallD", 32'(StallD), 1);
    check("lw FlushE", 32'(FlushE), 1);
    check("lw FlushD", 32'(FlushD), 0);
    tick();
    RdE = 0; Rs1D = 0; #2;
    check("lw x0 StallF", 32'(StallF), 0);
    tick(); idle();

    // Forwarding priority
    RegWriteM = 1; RdM = 3; RegWriteW = 1; RdW = 3; Rs1E = 3; #2;
    check("fwd M", 32'(ForwardAE), 2);
    tick();
    RegWriteM = 0; #2;
    check("fwd W", 32'(ForwardAE), 1);
    tick();
    RegWriteM = 1; RdM = 0; RdW = 0; #2;
    check("fwd x0", 32'(ForwardAE), 0);
    tick();
    RdM = 7; Rs2E = 7; #2;
    check("fwd B M", 32'(ForwardBE), 2);
    tick(); idle();

    // Plain miss, refill at cycle 10
    do_reset();
    icache_req = 1; #2;
    check("miss c0 StallF", 32'(StallF), 1);
    check("miss c0 FlushD", 32'(FlushD), 1);
    tick(); icache_req = 0;
    for (int i = 1; i <= 9; i++) begin
      #2;
      check("miss wait StallF", 32'(StallF), 1);
      check("miss wait FlushD", 32'(FlushD), 1);
      tick();
    end
    icache_ready = 1; #2;
    check("miss ready StallF", 32'(StallF), 1);
    tick(); icache_ready = 0; #2;
    check("miss done StallF", 32'(StallF), 0);
    check("miss stall_cycles", 32'(stall_cycles), 11);
    tick();

    // Branch redirect during a miss
    do_reset();
    icache_req = 1; tick(); icache_req = 0;
    tick(); tick(); tick();
    PCSrcE = 1; #2;
    check("br StallF", 32'(StallF), 0);
    check("br FlushD", 32'(FlushD), 1);
    check("br FlushE", 32'(FlushE), 1);
    tick(); PCSrcE = 0;
    for (int i = 5; i <= 9; i++) begin
      #2;
      check("cancel StallF", 32'(StallF), 1);
      tick();
    end
    icache_ready = 1; #2;
    check("cancel ready StallF", 32'(StallF), 1);
    tick(); icache_ready = 0; #2;
    check("cancel done StallF", 32'(StallF), 0);
    check("cancel stall_cycles", 32'(stall_cycles), 10);
    tick();

    // Redirect and refill in the same MISS cycle
    do_reset();
    icache_req = 1; tick(); icache_req = 0;
    PCSrcE = 1; icache_ready = 1; tick();
    PCSrcE = 0; icache_ready = 0; #2;
    check("same-cycle CANCEL StallF", 32'(StallF), 1);
    tick(); icache_ready = 1; tick(); icache_ready = 0; #2;
    check("same-cycle RUN StallF", 32'(StallF), 0);
    tick();

    // Timeout flag and counter saturation
    do_reset();
    icache_req = 1; tick(); icache_req = 0;
    repeat (7) tick();
    #2;
    check("timeout before", 32'(miss_timeout), 0);
    tick(); #2;
    check("timeout set", 32'(miss_timeout), 1);
    icache_ready = 1; tick(); icache_ready = 0; #2;
    check("timeout sticky", 32'(miss_timeout), 1);
    check("timeout RUN StallF", 32'(StallF), 0);
    tick();
    ResultSrcE0 = 1; RdE = 9; Rs2D = 9;
    repeat (20) tick();
    idle(); #2;
    check("stall saturate", 32'(stall_cycles), SATV);
    check("timeout still", 32'(miss_timeout), 1);
    tick();

    // Asynchronous reset in the middle of a miss
    icache_req = 1; tick(); icache_req = 0;
    tick(); tick();
    #2 rst = 0;
    #1;
    check("areset StallF", 32'(StallF), 0);
    check("areset FlushD", 32'(FlushD), 1);
    check("areset FlushE", 32'(FlushE), 1);
    check("areset stall_cycles", 32'(stall_cycles), 0);
    check("areset miss_timeout", 32'(miss_timeout), 0);
    tick(); rst = 1;
    tick(); tick();

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
`default_nettype wire
